// File: rtl/spi_slave_if.sv
// Local-bus side of the SPI target: transmit hold-register handshake,
// received-word delivery and status flags.
interface spi_slave_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] tx_data;
  logic                   tx_load;
  logic                   tx_ready;
  logic [WORD_LENGTH-1:0] rx_data;
  logic                   rx_data_valid;
  logic                   tx_underrun;
  logic                   busy;

  // Local bus controller that feeds transmit words and consumes received ones
  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_data_valid, tx_underrun, busy
  );

  // The SPI target engine
  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_data_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI target shift engine. SCLK/SSbar/MOSI are oversampled in the clk domain,
// words are shifted MSB first while SSbar is low, received words are handed to
// the local bus with a one-clk valid pulse and transmit words come from a
// one-entry hold register.
module spi_slave #(
  parameter int WORD_LENGTH = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       SSbar,
  input  logic       MOSI,
  output logic       MISO,
  spi_slave_if.slave bus
);

  localparam int                CNT_W    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state_q, state_d;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic mosi_p0, mosi_p1;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic word_start, word_done, sample_en, shift_en, go_idle;
  logic preload, load_ok, last_bit;

  logic [WORD_LENGTH-1:0] hold_q, tx_shift, rx_shift, rx_data_q;
  logic                   hold_full, rx_valid_q, underrun_q, miso_q;
  logic [CNT_W-1:0]       bit_cnt;

  // Two-flop synchronisers, plus a third SCLK/SSbar copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= CPOL;
      sclk_p1 <= CPOL;
      sclk_p2 <= CPOL;
      ss_p0   <= 1'b1;
      ss_p1   <= 1'b1;
      ss_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_p0   <= SSbar;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      mosi_p0 <= MOSI;
      mosi_p1 <= mosi_p0;
    end
  end

  assign lead_edge   = (sclk_p2 == CPOL) && (sclk_p1 != CPOL);
  assign trail_edge  = (sclk_p2 != CPOL) && (sclk_p1 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign ss_fall     = ss_p2 & ~ss_p1;
  assign ss_rise     = ~ss_p2 & ss_p1;

  assign last_bit = (bit_cnt == LAST_BIT);
  // In mode CPHA=0 the first bit must already be on MISO before the first
  // sample edge, so a word started from IDLE presents its MSB immediately.
  assign preload  = (state_q == IDLE) && !CPHA;
  assign load_ok  = bus.tx_load && !hold_full;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-clk datapath strobes. A word whose final sample
  // edge coincides with SSbar rising is still delivered; the frame then ends
  // without starting another word. Any other SSbar rise aborts the word.
  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    word_done  = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    go_idle    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (sample_edge && last_bit) begin
          sample_en = 1'b1;
          word_done = 1'b1;
          if (ss_rise) begin
            state_d = IDLE;
            go_idle = 1'b1;
          end else begin
            word_start = 1'b1;
          end
        end else if (ss_rise) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold register, shift registers, bit counter and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_full  <= 1'b0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (load_ok) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end
      if (sample_en) begin
        rx_shift <= {rx_shift[WORD_LENGTH-2:0], mosi_p1};
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data_q  <= {rx_shift[WORD_LENGTH-2:0], mosi_p1};
        rx_valid_q <= 1'b1;
        bit_cnt    <= '0;
      end
      if (shift_en) begin
        miso_q   <= tx_shift[WORD_LENGTH-1];
        tx_shift <= tx_shift << 1;
      end
      if (word_start) begin
        bit_cnt <= '0;
        if (hold_full) begin
          hold_full <= 1'b0;
          tx_shift  <= preload ? (hold_q << 1) : hold_q;
          if (preload) miso_q <= hold_q[WORD_LENGTH-1];
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
          if (preload) miso_q <= 1'b0;
        end
      end
      if (go_idle) miso_q <= 1'b0;
    end
  end

  assign MISO              = miso_q;
  assign bus.tx_ready      = ~hold_full;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_data_valid = rx_valid_q;
  assign bus.tx_underrun   = underrun_q;
  assign bus.busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 instance and a CPOL=1/CPHA=1 instance driven
// by a behavioural SPI master, checked against a word-level model of the
// hold register, underrun count and expected received words.
module tb_spi_slave;

  localparam int H = 4;  // SCLK half-period in clk cycles

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic m_sclk, m_ss, m_mosi;
  int   sel;
  logic sclk0, ss0, sclk3, ss3, miso0, miso3, m_miso;

  assign sclk0  = (sel == 0) ? m_sclk : 1'b0;
  assign ss0    = (sel == 0) ? m_ss   : 1'b1;
  assign sclk3  = (sel == 1) ? m_sclk : 1'b1;
  assign ss3    = (sel == 1) ? m_ss   : 1'b1;
  assign m_miso = (sel == 1) ? miso3  : miso0;

  spi_slave_if #(.WORD_LENGTH(8)) if0 ();
  spi_slave_if #(.WORD_LENGTH(8)) if3 ();

  spi_slave #(.WORD_LENGTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk0), .SSbar(ss0), .MOSI(m_mosi),
    .MISO(miso0), .bus(if0.slave)
  );

  spi_slave #(.WORD_LENGTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk3), .SSbar(ss3), .MOSI(m_mosi),
    .MISO(miso3), .bus(if3.slave)
  );

  int checks = 0;
  int errors = 0;

  // Word-level model
  bit         hold_full_m [2];
  logic [7:0] hold_val_m  [2];
  logic [7:0] cur_exp     [2];
  int         exp_ur      [2];
  int         act_ur      [2];
  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_rx0.size() : exp_rx1.size();
  endfunction

  function automatic logic ready_of(input int d);
    return (d == 0) ? if0.tx_ready : if3.tx_ready;
  endfunction

  // A word starts: the hold register supplies the word, or it underruns
  task automatic model_word_start(input int d);
    if (hold_full_m[d]) begin
      cur_exp[d]     = hold_val_m[d];
      hold_full_m[d] = 1'b0;
    end else begin
      cur_exp[d] = 8'h00;
      exp_ur[d]++;
    end
  endtask

  // Pulse tx_load for one clk; optionally wait (bounded) for tx_ready first
  task automatic load(input int d, input logic [7:0] w, input bit wait_ready);
    int n;
    n = 0;
    if (wait_ready) begin
      while (!ready_of(d) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL tx_ready wait: got timeout, required tx_ready=1");
      end
    end
    if (d == 0) begin if0.tx_data = w; if0.tx_load = 1'b1; end
    else        begin if3.tx_data = w; if3.tx_load = 1'b1; end
    if (!hold_full_m[d]) begin
      hold_full_m[d] = 1'b1;
      hold_val_m[d]  = w;
    end
    @(negedge clk);
    if0.tx_load = 1'b0;
    if3.tx_load = 1'b0;
  endtask

  task automatic start_frame();
    m_ss = 1'b0;
    model_word_start(sel);
    wait_h();
  endtask

  // Shift nbits (MSB first) of tx; when last is set, SSbar rises together with
  // the final sample edge so the slave closes the frame after this word.
  task automatic xfer_word(input logic [7:0] tx, input int nbits, input bit last,
                           output logic [7:0] rx);
    int         d;
    bit         cpol, cpha;
    logic [7:0] e;
    d    = sel;
    cpol = (sel == 1);
    cpha = (sel == 1);
    e    = cur_exp[d];
    rx   = 8'h00;
    if (nbits == 8) begin
      if (d == 0) exp_rx0.push_back(tx); else exp_rx1.push_back(tx);
    end
    for (int k = 0; k < nbits; k++) begin
      int i;
      bit fin;
      i   = 7 - k;
      fin = last && (k == nbits - 1);
      if (!cpha) begin
        m_mosi = tx[i];
        wait_h();
        m_sclk = ~cpol;
        rx[i]  = m_miso;
        if (fin) m_ss = 1'b1;
        wait_h();
        m_sclk = cpol;
      end else begin
        m_sclk = ~cpol;
        m_mosi = tx[i];
        wait_h();
        m_sclk = cpol;
        rx[i]  = m_miso;
        if (fin) m_ss = 1'b1;
        wait_h();
      end
    end
    if (nbits == 8) begin
      chk("master rx word vs model", rx, e);
      if (!last) model_word_start(d);
    end
  endtask

  // Wait (bounded) for all expected words, then check the underrun tally
  task automatic drain(input int d);
    int n;
    n = 0;
    repeat (6) @(negedge clk);
    while (qsize(d) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pending rx words", qsize(d), 0);
    chk("underrun count", act_ur[d], exp_ur[d]);
  endtask

  // Per-cycle compare of the received-word stream and underrun pulses
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (if0.rx_data_valid) begin
        checks++;
        if (exp_rx0.size() == 0) begin
          errors++;
          $display("FAIL rx0 valid: got pulse with 0x%0h, required none", if0.rx_data);
        end else begin
          e = exp_rx0.pop_front();
          if (if0.rx_data !== e) begin
            errors++;
            $display("FAIL rx0 word: got 0x%0h, required 0x%0h", if0.rx_data, e);
          end
        end
      end
      if (if3.rx_data_valid) begin
        checks++;
        if (exp_rx1.size() == 0) begin
          errors++;
          $display("FAIL rx3 valid: got pulse with 0x%0h, required none", if3.rx_data);
        end else begin
          e = exp_rx1.pop_front();
          if (if3.rx_data !== e) begin
            errors++;
            $display("FAIL rx3 word: got 0x%0h, required 0x%0h", if3.rx_data, e);
          end
        end
      end
      if (if0.tx_underrun) act_ur[0]++;
      if (if3.tx_underrun) act_ur[1]++;
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    int         ur_before;

    rst_n = 1'b0;
    sel = 0;
    m_sclk = 1'b0; m_ss = 1'b1; m_mosi = 1'b0;
    if0.tx_data = 8'h00; if0.tx_load = 1'b0;
    if3.tx_data = 8'h00; if3.tx_load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hold_full_m[d] = 1'b0; hold_val_m[d] = 8'h00; cur_exp[d] = 8'h00;
      exp_ur[d] = 0; act_ur[d] = 0;
    end
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset MISO", miso0, 1'b0);
    chk("reset tx_ready", if0.tx_ready, 1'b1);
    chk("reset rx_data", if0.rx_data, 8'h00);
    chk("reset rx_data_valid", if0.rx_data_valid, 1'b0);
    chk("reset tx_underrun", if0.tx_underrun, 1'b0);
    chk("reset busy", if0.busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 single word; a second load while full is ignored
    load(0, 8'hA5, 1'b1);
    load(0, 8'h77, 1'b0);
    chk("t1 tx_ready while full", if0.tx_ready, 1'b0);
    start_frame();
    chk("t1 tx_ready after word start", if0.tx_ready, 1'b1);
    chk("t1 busy in frame", if0.busy, 1'b1);
    xfer_word(8'h3C, 8, 1'b1, r0);
    chk("t1 master rx literal", r0, 8'hA5);
    drain(0);
    chk("t1 rx_data literal", if0.rx_data, 8'h3C);
    chk("t1 busy after frame", if0.busy, 1'b0);

    // Two back-to-back words in one frame
    ur_before = act_ur[0];
    load(0, 8'hA5, 1'b1);
    start_frame();
    load(0, 8'h5A, 1'b1);
    xfer_word(8'hC3, 8, 1'b0, r0);
    xfer_word(8'h81, 8, 1'b1, r1);
    chk("t2 master rx word1 literal", r0, 8'hA5);
    chk("t2 master rx word2 literal", r1, 8'h5A);
    drain(0);
    chk("t2 no underrun", act_ur[0] - ur_before, 0);
    chk("t2 rx_data literal", if0.rx_data, 8'h81);

    // Underrun: nothing loaded (the 0x77 load earlier must not show up)
    ur_before = act_ur[0];
    start_frame();
    xfer_word(8'hFF, 8, 1'b1, r0);
    chk("t3 master rx literal", r0, 8'h00);
    drain(0);
    chk("t3 one underrun", act_ur[0] - ur_before, 1);
    chk("t3 rx_data literal", if0.rx_data, 8'hFF);

    // Abort after 5 bits; hold register loaded mid-frame survives the abort
    start_frame();
    load(0, 8'h81, 1'b1);
    xfer_word(8'hA8, 5, 1'b0, r0);
    wait_h();
    m_ss = 1'b1;
    repeat (8) @(negedge clk);
    chk("t4 busy after abort", if0.busy, 1'b0);
    chk("t4 MISO after abort", miso0, 1'b0);
    chk("t4 hold kept", if0.tx_ready, 1'b0);
    chk("t4 rx_data unchanged", if0.rx_data, 8'hFF);
    start_frame();
    xfer_word(8'h81, 8, 1'b1, r0);
    chk("t4 master rx literal", r0, 8'h81);
    drain(0);
    chk("t4 rx_data literal", if0.rx_data, 8'h81);

    // CPOL=1, CPHA=1 instance
    sel = 1;
    m_sclk = 1'b1;
    repeat (4) @(negedge clk);
    load(1, 8'h96, 1'b1);
    start_frame();
    xfer_word(8'h69, 8, 1'b1, r0);
    chk("t5 master rx literal", r0, 8'h96);
    drain(1);
    chk("t5 rx_data literal", if3.rx_data, 8'h69);

    // Asynchronous reset mid-word with the hold register full
    sel = 0;
    m_sclk = 1'b0;
    repeat (4) @(negedge clk);
    load(0, 8'h11, 1'b1);
    start_frame();
    load(0, 8'h22, 1'b1);
    xfer_word(8'hF0, 3, 1'b0, r0);
    chk("t6 hold full before reset", if0.tx_ready, 1'b0);
    chk("t6 busy before reset", if0.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6 reset MISO", miso0, 1'b0);
    chk("t6 reset tx_ready", if0.tx_ready, 1'b1);
    chk("t6 reset rx_data", if0.rx_data, 8'h00);
    chk("t6 reset rx_data_valid", if0.rx_data_valid, 1'b0);
    chk("t6 reset busy", if0.busy, 1'b0);
    m_ss = 1'b1;
    m_sclk = 1'b0;
    hold_full_m[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ur_before = act_ur[0];
    start_frame();
    xfer_word(8'h5A, 8, 1'b1, r0);
    chk("t6 master rx after reset literal", r0, 8'h00);
    drain(0);
    chk("t6 one underrun after reset", act_ur[0] - ur_before, 1);
    chk("t6 rx_data literal", if0.rx_data, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
